// File: rtl/switch_capture.sv
// switch_capture: synchronizes the board switches and a bouncing confirm
// button, debounces the button, and captures the switch word into a
// CPU-readable data register with valid/overrun status.
// Optional feature macro: SWITCH_CAPTURE_LIVE_EN -- when defined, a data read
// with no captured word pending returns the live synchronized switches
// instead of the stored data register.
module switch_capture #(
    parameter int unsigned DEBOUNCE_CYCLES = 20'd100000,
    parameter int unsigned DATA_WIDTH      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] switches,
    input  logic                  confirm_button,
    input  logic                  ior,
    input  logic                  sel_data,
    input  logic                  sel_status,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  data_valid,
    output logic                  overrun
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_e;

    logic [DATA_WIDTH-1:0] sw_meta_q;
    logic [DATA_WIDTH-1:0] sw_sync_q;
    logic                  btn_meta_q;
    logic                  btn_sync_q;

    logic [1:0]            fill_q;
    logic                  armed_q;
    logic                  armed_d;

    state_e                state_q;
    state_e                state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  capture;

    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  valid_q;
    logic                  valid_d;
    logic                  overrun_q;
    logic                  overrun_d;

    logic                  data_read;
    logic                  status_read;

    assign data_read   = ior & sel_data;
    assign status_read = ior & sel_status & ~sel_data;

    // Two-flop synchronizers for the switch bus and the confirm button.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
        end else begin
            sw_meta_q  <= switches;
            sw_sync_q  <= sw_meta_q;
            btn_meta_q <= confirm_button;
            btn_sync_q <= btn_meta_q;
        end
    end

    // Press arming: the synchronizer resets to 0, so a button held through
    // reset would look like a fresh press. Only once the synchronizer has
    // refilled (fill_q[1]) and shows the button released do we accept a press.
    always_comb begin
        armed_d = armed_q | (fill_q[1] & ~btn_sync_q);
    end

    // Synchronizer fill tracker and arming flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fill_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            fill_q  <= {fill_q[0], 1'b1};
            armed_q <= armed_d;
        end
    end

    // Debounce FSM state and counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Debounce FSM next-state logic and single-cycle capture pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_sync_q && armed_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_sync_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!btn_sync_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_sync_q) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Data register, valid and overrun next-state from capture and reads.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (status_read) begin
            overrun_d = 1'b0;
        end
        if (capture) begin
            if (!valid_q || data_read) begin
                // Empty register, or the pending word is being read this
                // cycle: the new word replaces it and stays valid.
                data_d  = sw_sync_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (data_read) begin
            valid_d = 1'b0;
        end
    end

    // Data register, valid and overrun state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // Combinational read mux; sel_data wins when both selects are set.
    always_comb begin
        rdata = '0;
        if (data_read) begin
`ifdef SWITCH_CAPTURE_LIVE_EN
            rdata = valid_q ? data_q : sw_sync_q;
`else
            rdata = data_q;
`endif
        end else if (status_read) begin
            rdata = {{(DATA_WIDTH-2){1'b0}}, overrun_q, valid_q};
        end
    end

    assign data_valid = valid_q;
    assign overrun    = overrun_q;

endmodule

// File: doc/switch_capture.md
SWITCH_CAPTURE -- requirements
Module: switch_capture

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 20'd100000, number of consecutive stable synchronized samples that qualify a button press or release.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, width of the switch bus and of rdata.
REQ-003 SHALL have port clock  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port switches  input  DATA_WIDTH  raw board switches, asynchronous to clock.
REQ-006 SHALL have port confirm_button  input  1  raw confirm push-button, active-high, asynchronous and bouncing.
REQ-007 SHALL have port ior  input  1  CPU I/O read strobe from the Controller.
REQ-008 SHALL have port sel_data  input  1  address decode selecting the captured-data register.
REQ-009 SHALL have port sel_status  input  1  address decode selecting the status register.
REQ-010 SHALL have port rdata  output  DATA_WIDTH  read data returned to the memory/IO mux.
REQ-011 SHALL have port data_valid  output  1  captured word present and not yet read.
REQ-012 SHALL have port overrun  output  1  press occurred while data_valid was 1.

Function
REQ-013 SHALL pass switches and confirm_button through two-flop synchronizers before any use; capture uses the synchronized switches.
REQ-014 SHALL run a debounce FSM with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, using a counter wide enough for DEBOUNCE_CYCLES.
REQ-015 IDLE: synchronized button 1 -> PRESS_WAIT, counter cleared.
REQ-016 PRESS_WAIT: button 0 -> IDLE; button 1 -> counter increments; the count reaching DEBOUNCE_CYCLES-1 with button 1 -> HELD and one capture pulse.
REQ-017 HELD: button 0 -> RELEASE_WAIT, counter cleared; no further capture while held.
REQ-018 RELEASE_WAIT: button 1 -> HELD; DEBOUNCE_CYCLES consecutive 0 samples -> IDLE.
REQ-019 On a capture pulse with data_valid=0, SHALL load the synchronized switches into the data register and set data_valid on the same edge; data_valid and the data register are visible the next cycle.
REQ-020 On a capture pulse with data_valid=1 and no data read in that cycle, SHALL keep the data register, keep data_valid=1 and set overrun.
REQ-021 A data read is ior=1 and sel_data=1 in a cycle; it SHALL clear data_valid at the next edge, once per asserted cycle.
REQ-022 A capture pulse coinciding with a data read SHALL return the old word this cycle, load the new word, leave data_valid=1 and not set overrun.
REQ-023 A status read is ior=1 and sel_status=1; rdata SHALL be {zeros, overrun, data_valid} (bit1 overrun, bit0 valid), and overrun SHALL clear at the next edge unless a new overrun occurs in the same cycle.
REQ-024 rdata SHALL be combinational and SHALL be 0 whenever ior=0 or no select is asserted; sel_data has priority if both selects are 1.

Reset
REQ-025 Reset SHALL asynchronously force synchronizers to 0, FSM to IDLE, counter to 0, data register to 0, data_valid=0 and overrun=0.
REQ-026 Reset asserted mid-debounce or mid-hold SHALL discard the press; after release, a full press is required to capture.

Configuration
REQ-027 Macro SWITCH_CAPTURE_LIVE_EN: when defined, a data read with data_valid=0 SHALL return the live synchronized switches; when undefined, it SHALL return the stored data register. All other behaviour is identical.

Verification (DEBOUNCE_CYCLES=4 for simulation)
REQ-028 switches=16'h00A5, button high 10 cycles -> exactly one capture; data_valid=1; data read returns 16'h00A5; data_valid=0 one cycle later.
REQ-029 Button bounces 1,0,1,0 then stays high 2 cycles, then low -> no capture; data_valid=0.
REQ-030 Capture 16'h1234 unread, set switches=16'h5678, press again -> data read returns 16'h1234; status read before the data read returns 16'h0003; overrun=0 after the status read.
REQ-031 Capture pulse in the same cycle as a data read of 16'h0001 with switches=16'h0002 -> read returns 16'h0001; next data read returns 16'h0002; overrun=0.
REQ-032 Reset asserted while in PRESS_WAIT and while data_valid=1 -> all outputs 0 immediately, without waiting for a clock edge; holding the button through reset release yields no capture until it is released and pressed again.
REQ-033 Data read with data_valid=0 and switches=16'hBEEF -> rdata=16'hBEEF with SWITCH_CAPTURE_LIVE_EN defined, the last stored word (16'h0000 after reset) without it.
